uart_tx_top: RTL and testbench
==============================

Name: uart_tx_top

Overview:
- Top-level serial transmitter. A rising edge on i_tx_start sends one fixed byte over o_tx as an 8N1 UART frame (1 start bit, 8 data bits LSB-first, 1 stop bit, no parity).
- Contains three parts: a start-edge detector, a bit-period counter used as the baud generator, and a transmit FSM.
- Sits at the chip boundary and drives the serial line directly.

Parameters:
- CLK_FREQ, 125_000_000, input clock frequency in Hz (8 ns period).
- BAUD_RATE, 9600, serial bit rate in baud.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (integer division, 13020 by default), clock cycles per serial bit. Must be >= 2.
- TX_DATA, 8'h41, byte transmitted on each start request.

Ports:
- i_clock  input  1  system clock; all logic updates on its rising edge.
- i_reset  input  1  reset, synchronous and active-high.
- i_tx_start  input  1  transmit request; only its rising edge triggers a frame.
- o_tx  output  1  serial line. Registered. Idles high.

Behaviour:
- Reset: applies at a rising clock edge while i_reset=1. Sets state IDLE, o_tx=1, bit counter=0, cycle counter=0, start-edge history register=0. Reset overrides everything, including mid-frame: o_tx is 1 after that edge and the partial frame is abandoned.
- Edge detect: register the previous value of i_tx_start.
  - start_pulse = i_tx_start & ~prev.
  - A level held high does not retrigger.
  - A start_pulse while not IDLE is ignored (dropped, not queued).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_tx=1. On start_pulse, go to START, o_tx<=0 and cycle counter<=0 at the same edge. Latency is one cycle: o_tx goes low on the clock edge that samples the rising edge.
  - START: hold o_tx=0 for CLKS_PER_BIT cycles. At the end, go to DATA with bit index 0 and o_tx<=TX_DATA[0].
  - DATA: each bit lasts CLKS_PER_BIT cycles; bits are sent in order TX_DATA[0]..TX_DATA[7]. After bit 7 completes, go to STOP with o_tx<=1.
  - STOP: hold o_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Cycle counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Its width is $clog2(CLKS_PER_BIT).
- Total frame length: exactly 10*CLKS_PER_BIT cycles from the first low cycle to the first IDLE cycle.
- Back-to-back frames: a new start_pulse is accepted only in IDLE. The earliest new start bit comes one cycle after STOP completes, so there is no glitch between frames.
- TX_DATA is sampled into a shift/data register at frame start. Changing the parameter needs no runtime support.
- No busy/done outputs.

Test Plan:
- Reset: hold i_reset=1 for 5 cycles with i_tx_start=0 -> o_tx=1 throughout and after release; no transition for 1000 cycles.
- Single frame: i_tx_start pulse held 125 cycles, with defaults -> o_tx goes low one cycle after the rise. The line sequence is 0,1,0,0,0,0,0,1,0,1 (start, 0x41 LSB-first, stop), each bit exactly 13020 cycles. It then stays 1; holding i_tx_start high causes no second frame.
- Retrigger ignored: second rising edge of i_tx_start 40000 cycles into the frame -> frame unchanged; the line is idle at 130200 cycles and no extra frame follows.
- Second frame after idle: new pulse 2.5 ms (312500 cycles) after the first -> a second identical frame with the same timing.
- Reset mid-frame: assert i_reset during DATA bit 3 -> o_tx=1 from the next edge. After release, a new pulse yields a complete, correct frame.
- Small-parameter check: CLKS_PER_BIT=4, TX_DATA=8'hA5 -> 40-cycle frame with bits 0,1,0,1,0,0,1,0,1,1.

Source files
------------

// File: rtl/uart_tx_top.sv
// ----------------------------------------------------------------------------
// uart_tx_top
//
// Purpose:
//   Fixed-byte serial transmitter. Each rising edge on i_tx_start sends TX_DATA
//   once on o_tx as an 8N1 frame: one start bit (0), eight data bits LSB-first,
//   and one stop bit (1). Every bit lasts CLKS_PER_BIT clock cycles, so a frame
//   is exactly 10*CLKS_PER_BIT cycles long.
//
//   Internally the block has three parts:
//     - a start-edge detector that turns i_tx_start into a one-cycle pulse,
//     - a bit-period counter that acts as the baud generator,
//     - a transmit FSM (IDLE -> START -> DATA -> STOP -> IDLE).
//
// Parameters:
//   CLK_FREQ      input clock frequency in Hz
//   BAUD_RATE     serial bit rate in baud
//   CLKS_PER_BIT  clock cycles per serial bit (CLK_FREQ/BAUD_RATE); must be >= 2
//   TX_DATA       byte sent on each start request
//
// Ports:
//   i_clock     in   system clock; all state updates on its rising edge
//   i_reset     in   synchronous active-high reset; overrides a frame in flight
//   i_tx_start  in   transmit request; only its rising edge starts a frame
//   o_tx        out  registered serial line, idles high
// ----------------------------------------------------------------------------
module uart_tx_top #(
    parameter int          CLK_FREQ     = 125_000_000,
    parameter int          BAUD_RATE    = 9600,
    parameter int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter logic [7:0]  TX_DATA      = 8'h41
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_tx_start,
    output logic o_tx
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Cycle counter only has to reach CLKS_PER_BIT-1, so $clog2 bits suffice.
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST = 3'd7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       state;
    logic             start_prev;
    logic [CNT_W-1:0] cycle_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    logic start_pulse;
    logic bit_done;

    // ------------------------------------------------------------------------
    // Start-edge detector
    // ------------------------------------------------------------------------
    // A level held high yields a single pulse; the FSM only listens in IDLE,
    // so a pulse arriving mid-frame is simply dropped.
    assign start_pulse = i_tx_start & ~start_prev;

    // NOTE: sequential state is always written with non-blocking assignments
    // so every register samples the pre-edge values of the others.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            start_prev <= 1'b0;
        end else begin
            start_prev <= i_tx_start;
        end
    end

    // ------------------------------------------------------------------------
    // Bit-period counter (baud generator)
    // ------------------------------------------------------------------------
    // Counts 0..CLKS_PER_BIT-1 while a frame is in flight and wraps at each
    // bit boundary. bit_done marks the last cycle of the current bit.
    assign bit_done = (state != ST_IDLE) && (cycle_cnt == CNT_LAST);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cycle_cnt <= '0;
        end else if (state == ST_IDLE) begin
            // Held at zero so the start bit gets a full period from the
            // edge that accepts the request.
            cycle_cnt <= '0;
        end else if (bit_done) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Transmit FSM and serial output register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            o_tx      <= 1'b1;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_tx <= 1'b1;
                    if (start_pulse) begin
                        // Start bit goes out on the same edge that sees the
                        // request; the byte is latched for the whole frame.
                        state     <= ST_START;
                        o_tx      <= 1'b0;
                        shift_reg <= TX_DATA;
                        bit_idx   <= 3'd0;
                    end
                end

                ST_START: begin
                    if (bit_done) begin
                        state     <= ST_DATA;
                        o_tx      <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_idx   <= 3'd0;
                    end
                end

                ST_DATA: begin
                    if (bit_done) begin
                        if (bit_idx == BIT_LAST) begin
                            state <= ST_STOP;
                            o_tx  <= 1'b1;
                        end else begin
                            o_tx      <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            bit_idx   <= bit_idx + 3'd1;
                        end
                    end
                end

                ST_STOP: begin
                    // Line is already high; returning to IDLE keeps it high,
                    // so back-to-back frames never glitch.
                    if (bit_done) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    o_tx  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_top.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_top
//
// Two instances of uart_tx_top share one clock, reset and start request:
//   dut_a : CLKS_PER_BIT = 4 directly, TX_DATA = 8'hA5
//   dut_b : CLKS_PER_BIT derived from CLK_FREQ/BAUD_RATE = 130/10 = 13,
//           TX_DATA left at its default 8'h41
// A frame-level model (time since frame start -> line bit) predicts o_tx for
// each instance every cycle; literal bit patterns pin the model itself.
// ----------------------------------------------------------------------------
module tb_uart_tx_top;

    localparam int CPB_A = 4;
    localparam int CPB_B = 13;
    localparam logic [7:0] DATA_A = 8'hA5;
    localparam logic [7:0] DATA_B = 8'h41;

    logic clk;
    logic rst;
    logic tx_start;
    logic tx_a;
    logic tx_b;

    int errors;
    int checks;

    uart_tx_top #(
        .CLK_FREQ    (125_000_000),
        .BAUD_RATE   (9600),
        .CLKS_PER_BIT(CPB_A),
        .TX_DATA     (DATA_A)
    ) dut_a (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_tx_start(tx_start),
        .o_tx      (tx_a)
    );

    uart_tx_top #(
        .CLK_FREQ (130),
        .BAUD_RATE(10)
    ) dut_b (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_tx_start(tx_start),
        .o_tx      (tx_b)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Frame-level model: a frame is "elapsed cycles since the start bit"; the
    // line value is start=0, data bits LSB-first, stop=1, idle=1.
    // ------------------------------------------------------------------------
    function automatic logic line_bit(input int elapsed, input int cpb,
                                      input logic [7:0] data);
        int k;
        k = elapsed / cpb;
        if (k == 0)      return 1'b0;
        else if (k <= 8) return data[k-1];
        else             return 1'b1;
    endfunction

    bit   model_on;
    bit   busy   [2];
    int   elapsed[2];
    logic prev   [2];
    logic exp_tx [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int   cpb;
            logic [7:0] d;
            cpb = (i == 0) ? CPB_A : CPB_B;
            d   = (i == 0) ? DATA_A : DATA_B;
            if (rst) begin
                busy[i] = 1'b0;
                elapsed[i] = 0;
                prev[i] = 1'b0;
                model_on = 1'b1;
            end else begin
                logic pulse;
                pulse   = tx_start & ~prev[i];
                prev[i] = tx_start;
                if (busy[i]) begin
                    elapsed[i]++;
                    if (elapsed[i] == 10 * cpb) busy[i] = 1'b0;
                end else if (pulse) begin
                    busy[i] = 1'b1;
                    elapsed[i] = 0;
                end
            end
            exp_tx[i] = busy[i] ? line_bit(elapsed[i], cpb, d) : 1'b1;
        end
    end

    // One compare process, sampling half a cycle after each active edge.
    always @(negedge clk) begin
        if (model_on) begin
            check("tx_a_vs_model", tx_a, exp_tx[0]);
            check("tx_b_vs_model", tx_b, exp_tx[1]);
        end
    end

    // Literal frame pattern, sampled mid-bit. Call right after tx_start has
    // been raised on a negedge; negedge m after that sees elapsed = m-1.
    task automatic literal_frame(input string name, input int cpb,
                                 input logic [10:0] bits, input bit use_a);
        int at;
        at = 0;
        for (int k = 0; k <= 10; k++) begin
            int target;
            target = 1 + k * cpb + cpb / 2;
            repeat (target - at) @(negedge clk);
            at = target;
            check(name, use_a ? tx_a : tx_b, bits[k]);
        end
    endtask

    initial begin
        logic [10:0] pat_a;
        logic [10:0] pat_b;
        errors   = 0;
        checks   = 0;
        model_on = 1'b0;
        rst      = 1'b1;
        tx_start = 1'b0;

        // Bit k of each pattern is line bit k; bit 10 is the idle after stop.
        pat_a = 11'b11101001010;   // 0,1,0,1,0,0,1,0,1,1 then idle (0xA5)
        pat_b = 11'b11010000010;   // 0,1,0,0,0,0,0,1,0,1 then idle (0x41)

        // Reset held 5 cycles, then a long quiet stretch.
        repeat (5) @(negedge clk);
        check("reset_tx_a", tx_a, 1'b1);
        check("reset_tx_b", tx_b, 1'b1);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("idle_tx_a", tx_a, 1'b1);
        check("idle_tx_b", tx_b, 1'b1);

        // Single frame with the request held high past both frames.
        tx_start = 1'b1;
        fork
            literal_frame("literal_a", CPB_A, pat_a, 1'b1);
            literal_frame("literal_b", CPB_B, pat_b, 1'b0);
            repeat (200) @(negedge clk);
        join
        tx_start = 1'b0;
        repeat (20) @(negedge clk);

        // Retrigger inside a frame of dut_b (bit 3 region) is ignored.
        tx_start = 1'b1;
        repeat (3) @(negedge clk);
        tx_start = 1'b0;
        repeat (50) @(negedge clk);
        tx_start = 1'b1;
        repeat (3) @(negedge clk);
        tx_start = 1'b0;
        repeat (150) @(negedge clk);

        // Reset during dut_b data bit 3 (elapsed 4*13+5), then a clean frame.
        tx_start = 1'b1;
        repeat (1 + 4 * CPB_B + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_tx_b", tx_b, 1'b1);
        check("midreset_tx_a", tx_a, 1'b1);
        rst = 1'b0;
        tx_start = 1'b0;
        repeat (5) @(negedge clk);
        tx_start = 1'b1;
        fork
            literal_frame("after_reset_a", CPB_A, pat_a, 1'b1);
            literal_frame("after_reset_b", CPB_B, pat_b, 1'b0);
        join
        tx_start = 1'b0;
        repeat (10) @(negedge clk);

        // Randomized request toggling with occasional resets.
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b0;
            end else begin
                tx_start = ~tx_start;
                repeat ($urandom_range(1, 60)) @(negedge clk);
            end
        end
        tx_start = 1'b0;
        repeat (200) @(negedge clk);
        check("final_idle_a", tx_a, 1'b1);
        check("final_idle_b", tx_b, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
